// File: rtl/song_select_ctrl.sv
// Push-button front end for the melody player: synchronizes and debounces three
// buttons, then drives a one-hot song select with a silent gap on song changes.
module song_select_ctrl #(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int GAP_CYCLES      = 10000000,
    parameter int NUM_SONGS       = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         btn_play,
    input  logic                         btn_next,
    input  logic                         btn_prev,
    output logic [NUM_SONGS-1:0]         mode,
    output logic                         playing,
    output logic [$clog2(NUM_SONGS)-1:0] sel_idx
);
    localparam int SEL_W = $clog2(NUM_SONGS);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SONGS - 1);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    function automatic logic [NUM_SONGS-1:0] one_hot(input logic [SEL_W-1:0] s);
        return NUM_SONGS'(1) << s;
    endfunction

    function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] s, input logic fwd);
        if (fwd)
            return (s == SEL_LAST) ? '0 : s + 1'b1;
        else
            return (s == '0) ? SEL_LAST : s - 1'b1;
    endfunction

    // bit 0 = play, bit 1 = next, bit 2 = prev
    logic [2:0]      btn_raw;
    logic [2:0]      sync_p0;
    logic [2:0]      sync_p1;
    logic [2:0]      db_p2;
    logic [2:0]      db_q;
    logic [DB_W-1:0] db_cnt [3];
    logic [2:0]      press;

    assign btn_raw = {btn_prev, btn_next, btn_play};

    // stage 0/1: synchronizer, stage 2: debounced level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            db_p2   <= '0;
            db_q    <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
            db_q    <= db_p2;
            for (int i = 0; i < 3; i++) begin
                if (sync_p1[i] == db_p2[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_p2[i]  <= sync_p1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = db_p2 & ~db_q;

    state_t                state_q, state_d;
    logic [SEL_W-1:0]      sel_d;
    logic [GAP_W-1:0]      gap_cnt, gap_d;
    logic [NUM_SONGS-1:0]  mode_d;
    logic                  playing_d;
    logic                  do_play, do_nav;
    logic [SEL_W-1:0]      nav_sel;

    // next and prev in the same cycle cancel; play dominates both
    assign do_play = press[0];
    assign do_nav  = press[1] ^ press[2];
    assign nav_sel = sel_step(sel_idx, press[1]);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_idx;
        gap_d   = gap_cnt;
        case (state_q)
            IDLE: begin
                if (do_play)     state_d = PLAY;
                else if (do_nav) sel_d = nav_sel;
            end
            PLAY: begin
                if (do_play) begin
                    state_d = IDLE;
                end else if (do_nav) begin
                    sel_d   = nav_sel;
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                end
            end
            GAP: begin
                if (do_play) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else if (do_nav) begin
                    sel_d = nav_sel;
                    gap_d = GAP_LOAD;
                end else if (gap_cnt == '0) begin
                    state_d = PLAY;
                end else begin
                    gap_d = gap_cnt - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        mode_d    = (state_d == PLAY) ? one_hot(sel_d) : '0;
        playing_d = (state_d == PLAY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_idx <= '0;
            gap_cnt <= '0;
            mode    <= '0;
            playing <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_idx <= sel_d;
            gap_cnt <= gap_d;
            mode    <= mode_d;
            playing <= playing_d;
        end
    end
endmodule

// File: tb/tb_song_select_ctrl.sv
// Scoreboard bench for song_select_ctrl: directed button sequences push the
// expected output changes, a negedge monitor pops and checks each change.
module tb_song_select_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_play = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic [2:0] mode;
    logic       playing;
    logic [1:0] sel_idx;

    song_select_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .GAP_CYCLES     (8),
        .NUM_SONGS      (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_play(btn_play),
        .btn_next(btn_next),
        .btn_prev(btn_prev),
        .mode    (mode),
        .playing (playing),
        .sel_idx (sel_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] mode;
        logic       playing;
        logic [1:0] sel;
        int         hold;   // cycles the previous output must have lasted, 0 = any
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    bit         mon_en    = 1'b0;
    bit         have_prev = 1'b0;
    logic [5:0] prev_out;
    logic [5:0] cur_out;
    int         run_len;
    exp_t       e;

    localparam logic [2:0] B_PLAY = 3'b001;
    localparam logic [2:0] B_NEXT = 3'b010;
    localparam logic [2:0] B_PREV = 3'b100;

    function automatic void push_exp(input logic [2:0] m, input logic p, input logic [1:0] s, input int h);
        exp_t x;
        x.mode = m; x.playing = p; x.sel = s; x.hold = h;
        exp_q.push_back(x);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ($countones(mode) > 1) begin
                fails++;
                $display("FAIL onehot: mode=%b is multi-hot", mode);
            end
            cur_out = {mode, playing, sel_idx};
            if (!have_prev) begin
                have_prev = 1'b1;
                prev_out  = cur_out;
                run_len   = 1;
            end else if (cur_out != prev_out) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_change: got mode=%b playing=%b sel=%0d, expected no change",
                             mode, playing, sel_idx);
                end else begin
                    e = exp_q.pop_front();
                    if (cur_out != {e.mode, e.playing, e.sel}) begin
                        fails++;
                        $display("FAIL out_change: got mode=%b playing=%b sel=%0d, expected mode=%b playing=%b sel=%0d",
                                 mode, playing, sel_idx, e.mode, e.playing, e.sel);
                    end
                    if (e.hold != 0) begin
                        checks++;
                        if (run_len != e.hold) begin
                            fails++;
                            $display("FAIL hold_len: previous output lasted %0d cycles, expected %0d",
                                     run_len, e.hold);
                        end
                    end
                end
                prev_out = cur_out;
                run_len  = 1;
            end else begin
                run_len++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] b);
        btn_play = b[0];
        btn_next = b[1];
        btn_prev = b[2];
    endtask

    task automatic press(input string name, input logic [2:0] b, input int hold);
        int s0;
        int lat;
        s0  = exp_q.size();
        lat = 0;
        drive(b);
        for (int i = 1; i <= hold; i++) begin
            tick();
            if (lat == 0 && exp_q.size() < s0) lat = i;
        end
        drive(3'b000);
        for (int i = 0; i < 12; i++) tick();
        if (s0 > 0) chk_range({name, "_latency"}, lat, 7, 8);
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        repeat (3) tick();
        chk("reset_mode", int'(mode), 0);
        chk("reset_playing", int'(playing), 0);
        chk("reset_sel", int'(sel_idx), 0);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) tick();

        // short bounces never get through
        for (int k = 0; k < 5; k++) begin
            btn_next = 1'b1; repeat (3) tick();
            btn_next = 1'b0; repeat (3) tick();
        end
        repeat (10) tick();
        chk("bounce_sel", int'(sel_idx), 0);

        push_exp(3'b000, 1'b0, 2'd1, 0);
        press("next_hold", B_NEXT, 20);

        push_exp(3'b010, 1'b1, 2'd1, 0);
        press("play_on", B_PLAY, 10);
        push_exp(3'b000, 1'b0, 2'd1, 0);
        press("play_off", B_PLAY, 10);

        // wrap-around in IDLE
        push_exp(3'b000, 1'b0, 2'd0, 0);
        press("prev_a", B_PREV, 10);
        push_exp(3'b000, 1'b0, 2'd2, 0);
        press("prev_wrap", B_PREV, 10);
        push_exp(3'b000, 1'b0, 2'd0, 0);
        press("next_wrap", B_NEXT, 10);
        push_exp(3'b000, 1'b0, 2'd1, 0);
        press("next_b", B_NEXT, 10);
        push_exp(3'b000, 1'b0, 2'd2, 0);
        press("next_c", B_NEXT, 10);
        push_exp(3'b100, 1'b1, 2'd2, 0);
        press("play_song2", B_PLAY, 10);
        push_exp(3'b000, 1'b0, 2'd2, 0);
        press("stop_song2", B_PLAY, 10);
        push_exp(3'b000, 1'b0, 2'd0, 0);
        press("next_wrap2", B_NEXT, 10);

        // plain gap 001 -> 8 x 000 -> 010
        push_exp(3'b001, 1'b1, 2'd0, 0);
        press("play_song0", B_PLAY, 10);
        push_exp(3'b000, 1'b0, 2'd1, 0);
        push_exp(3'b010, 1'b1, 2'd1, 8);
        press("gap_next", B_NEXT, 20);

        // next, then prev three cycles later inside the gap: counter reloads
        push_exp(3'b000, 1'b0, 2'd2, 0);
        push_exp(3'b000, 1'b0, 2'd1, 3);
        push_exp(3'b010, 1'b1, 2'd1, 8);
        btn_next = 1'b1;
        repeat (3) tick();
        btn_prev = 1'b1;
        repeat (22) tick();
        drive(3'b000);
        repeat (12) tick();
        chk("gap_reload_drained", exp_q.size(), 0);

        // next+prev together cancel
        press("next_prev_cancel", B_NEXT | B_PREV, 10);
        chk("cancel_sel", int'(sel_idx), 1);
        chk("cancel_mode", int'(mode), 2);

        // play beats next
        push_exp(3'b000, 1'b0, 2'd1, 0);
        press("play_beats_next", B_PLAY | B_NEXT, 10);
        chk("play_beats_next_sel", int'(sel_idx), 1);

        // reset on the 4th gap cycle, play held through reset release
        push_exp(3'b010, 1'b1, 2'd1, 0);
        press("play_again", B_PLAY, 10);
        push_exp(3'b000, 1'b0, 2'd2, 0);
        push_exp(3'b000, 1'b0, 2'd0, 4);
        btn_next = 1'b1;
        n = 0;
        while (exp_q.size() == 2 && n < 20) begin
            tick();
            n++;
        end
        chk("gap_entered", exp_q.size(), 1);
        repeat (3) tick();
        rst = 1'b1;
        btn_next = 1'b0;
        btn_play = 1'b1;
        tick();
        chk("rst_gap_drained", exp_q.size(), 0);
        chk("rst_playing", int'(playing), 0);
        rst = 1'b0;
        push_exp(3'b001, 1'b1, 2'd0, 0);
        n = 0;
        while (exp_q.size() > 0 && n < 30) begin
            tick();
            n++;
        end
        chk("rst_release_latency", n, 7);
        repeat (10) tick();
        btn_play = 1'b0;
        repeat (12) tick();
        chk("final_drained", exp_q.size(), 0);
        chk("final_mode", int'(mode), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
